// File: rtl/arashi_mt_mem_pkg.sv
// Shared types for the multi-thread shared word memory.
//   arashi_ctrl_e    : per-thread request code carried on req_ctrl
//   arashi_mem_st_e  : top-level sequencing states
//   ctrl_has_rsp()   : true for request codes that produce a response word
package arashi_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'b00,
        CTRL_READ  = 2'b01,
        CTRL_WRITE = 2'b10,
        CTRL_RMW   = 2'b11
    } arashi_ctrl_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_RMW_WB = 2'b10
    } arashi_mem_st_e;

    function automatic logic ctrl_has_rsp(arashi_ctrl_e c);
        return (c == CTRL_READ) || (c == CTRL_RMW);
    endfunction

endpackage

// File: rtl/arashi_mt_mem_if.sv
// Request/response bundle between THREAD_NUM requesting threads and the shared memory.
//   req_ctrl  [2*T]   per-thread op code (idle/read/write/atomic add)
//   req_addr  [MW*T]  per-thread word address
//   req_wdata [DW*T]  per-thread write data / addend
//   req_ready [T]     one-hot grant
//   rsp_valid [T]     one-cycle response pulse
//   rsp_data  [DW*T]  per-thread response word (held between responses)
//   init_done         memory zero-fill complete
// master = thread side, slave = memory side.
interface arashi_mt_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 10,
    parameter int THREAD_NUM = 4
);
    logic [2*THREAD_NUM-1:0]          req_ctrl;
    logic [MEM_WIDTH*THREAD_NUM-1:0]  req_addr;
    logic [DATA_WIDTH*THREAD_NUM-1:0] req_wdata;
    logic [THREAD_NUM-1:0]            req_ready;
    logic [THREAD_NUM-1:0]            rsp_valid;
    logic [DATA_WIDTH*THREAD_NUM-1:0] rsp_data;
    logic                             init_done;

    modport master (
        output req_ctrl, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, init_done
    );

    modport slave (
        input  req_ctrl, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, init_done
    );
endinterface

// File: rtl/arashi_mt_mem_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req     [N]   pending requests
//   ptr     [IW]  highest-priority index this cycle
//   gnt     [N]   one-hot grant (zero when nothing pending)
//   gnt_idx [IW]  index of the granted requester
//   nxt     [IW]  gnt_idx+1 modulo N, the pointer value after this grant
//   any           a grant was issued
module arashi_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic [IW-1:0] nxt,
    output logic          any
);
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic          found_hi;

    // Lowest pending index at/after ptr, else lowest pending overall (wrap).
    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        any      = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                any    = 1'b1;
                idx_lo = IW'(i);
                if (i >= int'(ptr)) begin
                    found_hi = 1'b1;
                    idx_hi   = IW'(i);
                end
            end
        end
        gnt_idx = found_hi ? idx_hi : idx_lo;
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (gnt_idx == IW'(i));
        end
        nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
endmodule

// File: rtl/arashi_mt_mem.sv
// Shared single-port word memory for THREAD_NUM threads with round-robin grant,
// read / write / atomic add, and a zero-fill pass after reset.
//   clk   system clock
//   rstn  asynchronous reset, active low
//   bus   arashi_mt_mem_if.slave (request/response bundle, see interface)
//
// state     | meaning
// ST_INIT   | zero-fill one word per cycle, no grants
// ST_RUN    | arbitrate, one access per cycle
// ST_RMW_WB | write back old+addend for the atomic add granted last cycle, no grant
module arashi_mt_mem
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 10,
    parameter int THREAD_NUM = 4
) (
    input logic            clk,
    input logic            rstn,
    arashi_mt_mem_if.slave bus
);
    localparam int DEPTH = 2 ** MEM_WIDTH;
    localparam int IW    = $clog2(THREAD_NUM);

    if (THREAD_NUM < 2 || THREAD_NUM > 32) begin : g_param_check
        $error("arashi_mt_mem: THREAD_NUM must be in 2..32");
    end

    arashi_mem_st_e         st_q;
    logic [IW-1:0]          ptr_q;
    logic [IW-1:0]          rsp_tid_q;
    logic                   rsp_vld_q;
    logic                   init_done_q;
    logic [MEM_WIDTH-1:0]   init_cnt_q;
    logic [MEM_WIDTH-1:0]   wb_addr_q;
    logic [DATA_WIDTH-1:0]  wb_add_q;
    logic [DATA_WIDTH-1:0]  rd_q;
    logic [DATA_WIDTH-1:0]  hold_q [THREAD_NUM];
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [THREAD_NUM-1:0]  pending;
    logic [THREAD_NUM-1:0]  gnt;
    logic [IW-1:0]          gnt_idx;
    logic [IW-1:0]          nxt_ptr;
    logic                   gnt_any;
    logic                   run_gnt;

    arashi_ctrl_e           g_ctrl;
    logic [MEM_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]  g_wdata;

    logic                   mem_we;
    logic                   mem_re;
    logic [MEM_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    always_comb begin
        pending = '0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            pending[i] = (bus.req_ctrl[2*i +: 2] != 2'b00);
        end
    end

    arashi_rr_arbiter #(
        .N  (THREAD_NUM),
        .IW (IW)
    ) u_arb (
        .req     (pending),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .nxt     (nxt_ptr),
        .any     (gnt_any)
    );

    assign run_gnt       = (st_q == ST_RUN) && gnt_any;
    assign bus.req_ready = (st_q == ST_RUN) ? gnt : '0;

    // Fields of the granted thread; one-hot select keeps indices constant.
    always_comb begin
        g_ctrl  = CTRL_IDLE;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            if (gnt[i]) begin
                g_ctrl  = arashi_ctrl_e'(bus.req_ctrl[2*i +: 2]);
                g_addr  = bus.req_addr[i*MEM_WIDTH +: MEM_WIDTH];
                g_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Single memory port: exactly one of fill, granted access or writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = g_addr;
        mem_wdata = g_wdata;
        case (st_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = init_cnt_q;
                mem_wdata = '0;
            end
            ST_RUN: begin
                mem_we = run_gnt && (g_ctrl == CTRL_WRITE);
                mem_re = run_gnt && ctrl_has_rsp(g_ctrl);
            end
            ST_RMW_WB: begin
                mem_we    = 1'b1;
                mem_addr  = wb_addr_q;
                mem_wdata = rd_q + wb_add_q;
            end
            default: ;
        endcase
    end

    // Read-first synchronous array; rd_q holds the old word through RMW_WB.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q        <= ST_INIT;
            ptr_q       <= '0;
            rsp_tid_q   <= '0;
            rsp_vld_q   <= 1'b0;
            init_done_q <= 1'b0;
            init_cnt_q  <= '0;
            wb_addr_q   <= '0;
            wb_add_q    <= '0;
            for (int i = 0; i < THREAD_NUM; i++) hold_q[i] <= '0;
        end else begin
            rsp_vld_q <= 1'b0;
            if (rsp_vld_q) begin
                for (int i = 0; i < THREAD_NUM; i++) begin
                    if (rsp_tid_q == IW'(i)) hold_q[i] <= rd_q;
                end
            end
            case (st_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == '1) begin
                        st_q        <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_gnt) begin
                        ptr_q <= nxt_ptr;
                        if (ctrl_has_rsp(g_ctrl)) begin
                            rsp_vld_q <= 1'b1;
                            rsp_tid_q <= gnt_idx;
                        end
                        if (g_ctrl == CTRL_RMW) begin
                            st_q      <= ST_RMW_WB;
                            wb_addr_q <= g_addr;
                            wb_add_q  <= g_wdata;
                        end
                    end
                end
                ST_RMW_WB: st_q <= ST_RUN;
                default:   st_q <= ST_INIT;
            endcase
        end
    end

    // Response word is live from rd_q in the valid cycle, then held per thread.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            bus.rsp_valid[i] = rsp_vld_q && (rsp_tid_q == IW'(i));
            bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] =
                (rsp_vld_q && (rsp_tid_q == IW'(i))) ? rd_q : hold_q[i];
        end
    end

    assign bus.init_done = init_done_q;

endmodule
